// File: rtl/data_pipe_m2s_rr_sched_if.sv
// Handshake bundle between the round-robin scheduler and its environment:
// the raw upstream valids/readies going in, gating and path select coming out.
interface data_pipe_m2s_rr_sched_if #(
    parameter int unsigned NUM   = 8,
    parameter int unsigned QUOTA = 16
);
    localparam int unsigned NSIZE = $clog2(NUM);
    localparam int unsigned QSIZE = $clog2(QUOTA + 1);

    logic [NUM-1:0]   up_vld;
    logic [NUM-1:0]   up_ready;
    logic             m_vld;
    logic [NUM-1:0]   gate_vld;
    logic [NSIZE-1:0] addr;
    logic             grant_vld;
    logic [QSIZE-1:0] beat_cnt;
    logic             rotate;

    modport master (
        input  up_vld, up_ready, m_vld,
        output gate_vld, addr, grant_vld, beat_cnt, rotate
    );

    modport slave (
        output up_vld, up_ready, m_vld,
        input  gate_vld, addr, grant_vld, beat_cnt, rotate
    );
endinterface

// File: rtl/data_pipe_m2s_rr_sched.sv
// Round-robin scheduler for the multi-slave-to-single-master data pipe: picks a source,
// waits for the interconnect to drain and latch the new path, then grants up to QUOTA beats.
module data_pipe_m2s_rr_sched #(
    parameter int unsigned NUM   = 8,
    parameter int unsigned NSIZE = $clog2(NUM),
    parameter int unsigned QUOTA = 16,
    parameter int unsigned QSIZE = $clog2(QUOTA + 1)
) (
    input  logic                        clock,
    input  logic                        rst_n,
    input  logic                        clk_en,
    data_pipe_m2s_rr_sched_if.master    bus
);

    typedef enum logic [1:0] {StIdle, StDrain, StSettle, StGrant} state_e;

    state_e           state_q, state_d;
    logic [NSIZE-1:0] addr_q, addr_d;
    logic [NSIZE-1:0] last_q, last_d;
    logic [QSIZE-1:0] cnt_q, cnt_d;

    logic [NUM-1:0]   sel;
    logic [NSIZE-1:0] nxt;
    logic [NSIZE-1:0] pick_idx;
    logic             pick_found;
    logic             in_grant;
    logic             fire;
    logic             quota_hit;
    logic             any_other;
    logic             end_grant;

    always_comb begin
        sel         = '0;
        sel[addr_q] = 1'b1;
    end

    // Scan last+1, last+2, ... cyclically; last itself is the final candidate.
    always_comb begin
        nxt        = last_q;
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int unsigned k = 1; k <= NUM; k++) begin
            pick_idx = NSIZE'((32'(last_q) + k) % NUM);
            if (!pick_found && bus.up_vld[pick_idx]) begin
                nxt        = pick_idx;
                pick_found = 1'b1;
            end
        end
    end

    assign in_grant  = (state_q == StGrant);
    assign fire      = in_grant & bus.up_vld[addr_q] & bus.up_ready[addr_q] & clk_en;
    assign quota_hit = fire & (cnt_q == QSIZE'(QUOTA - 1));
    assign any_other = |(bus.up_vld & ~sel);
    // A grant only ends when someone else is waiting; a lone source keeps the path open.
    assign end_grant = in_grant & clk_en & any_other & (quota_hit | ~bus.up_vld[addr_q]);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        if (clk_en) begin
            unique case (state_q)
                StIdle: begin
                    if (|bus.up_vld) begin
                        addr_d  = nxt;
                        state_d = StDrain;
                    end
                end
                StDrain: begin
                    if (!bus.m_vld) state_d = StSettle;
                end
                StSettle: begin
                    state_d = StGrant;
                    cnt_d   = '0;
                    last_d  = addr_q;
                end
                StGrant: begin
                    if (fire) begin
                        if (quota_hit && !any_other) cnt_d = '0;
                        else if (cnt_q != QSIZE'(QUOTA)) cnt_d = cnt_q + QSIZE'(1);
                    end
                    if (end_grant) begin
                        if (|bus.up_vld) begin
                            addr_d  = nxt;
                            state_d = StDrain;
                        end else begin
                            state_d = StIdle;
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            addr_q  <= '0;
            last_q  <= NSIZE'(NUM - 1);
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        bus.gate_vld  = in_grant ? sel : '0;
        bus.addr      = addr_q;
        bus.grant_vld = in_grant;
        bus.beat_cnt  = cnt_q;
        bus.rotate    = end_grant;
    end

endmodule

// File: tb/tb_data_pipe_m2s_rr_sched.sv
// Randomized scoreboard bench: each episode queues the expected grant sequence
// (source, beats) and a negedge monitor pops one entry per rotate pulse.
module tb_data_pipe_m2s_rr_sched;

    localparam int NUM = 8;
    localparam int Q   = 4;

    typedef struct {
        int addr;
        int beats;
    } grant_t;

    logic clock  = 1'b0;
    logic rst_n  = 1'b1;
    logic clk_en = 1'b0;

    data_pipe_m2s_rr_sched_if #(.NUM(NUM), .QUOTA(Q)) bus ();

    data_pipe_m2s_rr_sched #(.NUM(NUM), .QUOTA(Q)) dut (
        .clock  (clock),
        .rst_n  (rst_n),
        .clk_en (clk_en),
        .bus    (bus)
    );

    always #5 clock = ~clock;

    grant_t exp_q[$];
    int     checks    = 0;
    int     errors    = 0;
    int     mon_beats = 0;

    task automatic check(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, got, want, $time);
        end
    endtask

    // Reference round-robin: first requester after 'last', wrapping, 'last' checked last.
    function automatic int rr_next(input logic [NUM-1:0] mask, input int last);
        for (int k = 1; k <= NUM; k++) begin
            int i;
            i = (last + k) % NUM;
            if (mask[i]) return i;
        end
        return -1;
    endfunction

    // Monitor: per-cycle gate/counter sanity plus grant-level scoreboard on rotate.
    always @(negedge clock) begin
        if (!rst_n) begin
            mon_beats = 0;
        end else begin
            if (bus.grant_vld) begin
                check("gate_onehot", int'(bus.gate_vld), 1 << bus.addr);
                check("beat_cnt", int'(bus.beat_cnt), mon_beats % Q);
            end else begin
                check("gate_closed", int'(bus.gate_vld), 0);
            end
            if (clk_en && |(bus.gate_vld & bus.up_vld & bus.up_ready)) mon_beats++;
            if (bus.rotate) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rotate: rotate at addr %0d, expected none at %0t",
                             bus.addr, $time);
                end else begin
                    grant_t e;
                    e = exp_q.pop_front();
                    check("grant_addr", int'(bus.addr), e.addr);
                    check("grant_beats", mon_beats, e.beats);
                end
                mon_beats = 0;
            end
        end
    end

    task automatic check_reset_outputs();
        check("rst_gate", int'(bus.gate_vld), 0);
        check("rst_grant", int'(bus.grant_vld), 0);
        check("rst_addr", int'(bus.addr), 0);
        check("rst_cnt", int'(bus.beat_cnt), 0);
        check("rst_rotate", int'(bus.rotate), 0);
    endtask

    // Asserts reset between clock edges and checks the outputs clear before the next edge.
    task automatic reset_dut(input bit expect_grant);
        @(posedge clock);
        #3;
        if (expect_grant) check("grant_before_reset", int'(bus.grant_vld), 1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs();
        bus.up_vld   = '0;
        bus.up_ready = '0;
        bus.m_vld    = 1'b0;
        clk_en       = 1'b1;
        exp_q.delete();
        repeat (2) @(posedge clock);
        #1 rst_n = 1'b1;
    endtask

    // Lone requester: 3-cycle grant latency, then quota wraps with no rotate and no gate gap.
    task automatic latency_test(input int src);
        int got;
        int cyc;
        got = -1;
        @(posedge clock);
        #1;
        bus.up_vld   = NUM'(1 << src);
        bus.up_ready = '1;
        bus.m_vld    = 1'b0;
        clk_en       = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            @(posedge clock);
            #1;
            if (bus.grant_vld && got < 0) got = c;
        end
        check("grant_latency", got, 3);
        check("first_addr", int'(bus.addr), src);
        cyc = 0;
        while (mon_beats < 3 * Q + 1 && cyc < 500) begin
            bus.up_ready[src] = ($urandom_range(0, 3) != 0);
            clk_en            = ($urandom_range(0, 3) != 0);
            @(posedge clock);
            #1;
            cyc++;
            check("gate_held", int'(bus.gate_vld), 1 << src);
        end
        check("lone_beats_reached", int'(mon_beats >= 3 * Q + 1), 1);
        reset_dut(1'b1);
    endtask

    // Interconnect busy: stay drained with addr fixed, grant two edges after m_vld falls.
    task automatic mvld_hold_test(input int src);
        int got;
        got = -1;
        @(posedge clock);
        #1;
        bus.m_vld    = 1'b1;
        bus.up_vld   = NUM'(1 << src);
        bus.up_ready = '1;
        clk_en       = 1'b1;
        repeat (10) begin
            @(posedge clock);
            #1;
            check("drain_gate", int'(bus.gate_vld), 0);
            check("drain_grant", int'(bus.grant_vld), 0);
            check("drain_addr", int'(bus.addr), src);
        end
        bus.m_vld = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            @(posedge clock);
            #1;
            if (bus.grant_vld && got < 0) got = c;
        end
        check("grant_after_mvld", got, 2);
        reset_dut(1'b1);
    endtask

    // Random episode: constant request mask, random ready/clk_en/m_vld. With 'drop' the
    // first grantee stops requesting after k accepted beats.
    task automatic run_episode(input bit drop);
        logic [NUM-1:0] mask;
        logic [NUM-1:0] rem;
        int             g, k, n, last, fired, cyc;
        bit             dropped;
        grant_t         e;
        k = 0;
        do begin
            for (int i = 0; i < NUM; i++) mask[i] = 1'($urandom_range(0, 1));
        end while ($countones(mask) < 2);
        g = rr_next(mask, NUM - 1);
        if (drop) begin
            k       = $urandom_range(1, Q - 1);
            e.addr  = g;
            e.beats = k;
            exp_q.push_back(e);
            rem     = mask;
            rem[g]  = 1'b0;
            last    = g;
            n       = ($countones(rem) >= 2) ? $urandom_range(2, 5) : 0;
        end else begin
            rem  = mask;
            last = NUM - 1;
            n    = $urandom_range(3, 8);
        end
        for (int j = 0; j < n; j++) begin
            last    = rr_next(rem, last);
            e.addr  = last;
            e.beats = Q;
            exp_q.push_back(e);
        end
        @(posedge clock);
        #1 bus.up_vld = mask;
        fired   = 0;
        dropped = 1'b0;
        cyc     = 0;
        while (exp_q.size() != 0 && cyc < 3000) begin
            for (int i = 0; i < NUM; i++) bus.up_ready[i] = ($urandom_range(0, 3) != 0);
            clk_en    = ($urandom_range(0, 3) != 0);
            bus.m_vld = ($urandom_range(0, 3) == 0);
            @(negedge clock);
            if (drop && !dropped && clk_en && bus.gate_vld[g] && bus.up_ready[g]) fired++;
            @(posedge clock);
            #1;
            cyc++;
            if (drop && !dropped && fired == k) begin
                bus.up_vld[g] = 1'b0;
                dropped       = 1'b1;
            end
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL episode_timeout: %0d grants outstanding, expected 0", exp_q.size());
        end
        reset_dut(1'b0);
    endtask

    initial begin
        bus.up_vld   = '0;
        bus.up_ready = '0;
        bus.m_vld    = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        check_reset_outputs();
        repeat (2) @(posedge clock);
        #1 rst_n = 1'b1;

        latency_test(0);
        mvld_hold_test($urandom_range(1, NUM - 1));
        latency_test(NUM - 1);
        for (int ep = 0; ep < 12; ep++) run_episode(1'b0);
        for (int ep = 0; ep < 8; ep++) run_episode(1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/data_pipe_m2s_rr_sched.md
Name: data_pipe_m2s_rr_sched

Overview:
- Round-robin scheduler that sequences the multi-slave-to-single-master data pipe interconnect.
- Drives the interconnect `addr` input.
- Gates each upstream `valid` before it reaches the interconnect, so a path change happens only when the interconnect has relaxed to idle.
- Enforces a per-grant beat quota so one source cannot starve the others.

Parameters:
- NUM, 8, number of upstream sources.
- NSIZE, $clog2(NUM), width of addr.
- QUOTA, 16, maximum beats accepted per grant before forced rotation (>=1).
- QSIZE, $clog2(QUOTA+1), width of beat counter.

Ports:
- clock  in  1  single clock.
- rst_n  in  1  asynchronous active-low reset.
- clk_en  in  1  global advance enable; when low, all state, counters and outputs hold.
- up_vld  in  NUM  raw valid of each source, ungated.
- up_ready  in  NUM  ready returned by the interconnect to each source.
- m_vld  in  1  interconnect master-side valid (m00.valid).
- gate_vld  out  NUM  per-source valid enable; interconnect sees up_vld & gate_vld.
- addr  out  NSIZE  path select to interconnect.
- grant_vld  out  1  high in GRANT state.
- beat_cnt  out  QSIZE  beats accepted in current grant.
- rotate  out  1  one-cycle pulse when a grant ends.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE; gate_vld=0; addr=0; grant_vld=0; beat_cnt=0; rotate=0.
  - rr pointer last=NUM-1, so first pick scans from index 0.
- fire = up_vld[addr] & gate_vld[addr] & up_ready[addr] & clk_en.
- Round-robin pick: nxt = first index i with up_vld[i]=1, scanning last+1, last+2, ... cyclically (wraps NUM-1 -> 0). This includes last itself as the final candidate.
- States:
  - IDLE: gate_vld=0. If clk_en & |up_vld: addr<=nxt, go DRAIN.
  - DRAIN: gate_vld=0, addr held. Wait for m_vld==0 with clk_en, then go SETTLE. (With the gated valid low and the connector empty, the interconnect returns to IDLE and latches addr into its current path.)
  - SETTLE: gate_vld=0 for exactly one clk_en cycle, so the interconnect path register is updated. Then go GRANT: beat_cnt<=0, last<=addr.
  - GRANT:
    - gate_vld = one-hot(addr); grant_vld=1; beat_cnt increments on fire, saturating at QUOTA.
    - End of grant condition: (fire & beat_cnt==QUOTA-1) or (up_vld[addr]==0 & any other up_vld set).
    - On end of grant: rotate=1 for one cycle. gate_vld drops the next cycle. Go IDLE if no up_vld is set, else addr<=nxt (computed with last=current addr) and go DRAIN.
    - Quota reached with no other requester: beat_cnt<=0, stay in GRANT, no rotate, no gate gap.
    - Selected source idle with no other requester: stay in GRANT, gate held.
- Simultaneous events:
  - fire on the quota beat while up_vld[addr] drops counts as a quota end: one rotate pulse only.
  - A new requester arriving in DRAIN/SETTLE does not change addr; it is arbitrated at the next pick.
- addr changes only in IDLE -> DRAIN or GRANT -> DRAIN transitions. It is never changed while gate_vld != 0.
- gate_vld is at most one-hot at all times.
- clk_en low freezes every register, including in DRAIN/SETTLE waits.
- Reset asserted mid-grant: gate_vld clears immediately (async), and a partially sent stream is abandoned.
- Latency: first grant is asserted no earlier than 3 clk_en cycles after the request (IDLE -> DRAIN -> SETTLE -> GRANT) when m_vld=0.

Test Plan:
- Single source 2 requests continuously, up_ready=1, m_vld=0, QUOTA=16 -> addr=2; gate_vld=8'b00000100 from cycle 3; beat_cnt wraps 15->0 with no rotate; gate never drops.
- Sources 1 and 5 both continuous, QUOTA=4 -> grants alternate 1,5,1,5; exactly 4 fires per grant; rotate pulses once per grant; gate_vld=0 for >=2 cycles between grants.
- Source 7 granted, then source 0 requests and 7 drops valid after 3 beats -> rotate, addr wraps 7->0; beat_cnt restarts at 0.
- Switch requested while m_vld held high 10 cycles -> state stays DRAIN; gate_vld=0 throughout; addr stable; GRANT follows 2 cycles after m_vld falls.
- clk_en toggled 50% during a QUOTA=4 grant -> only beats with clk_en=1 counted; rotate after the 4th counted fire; state frozen on clk_en=0 cycles.
- rst_n asserted asynchronously mid-GRANT (between clock edges) -> gate_vld=0, grant_vld=0 before the next clock edge; after release, first pick is index 0 if requesting.
